// File: rtl/acc_drain.sv
// ---------------------------------------------------------------------------
// acc_drain
//
// Result-side drain engine for the systolic-array accelerator. Once a tile has
// finished, this block walks the accumulator buffer one row at a time. Each
// 24-bit partial sum is requantized to an 8-bit activation, and the results
// are streamed out one element per beat over a valid/ready handshake.
//
// Per-row sequence: READ (issue address) -> WAIT (capture row) -> STREAM
// (SYS_COLS beats). There is no prefetch, so rows are separated by a 2-cycle
// gap with no valid beat.
//
// Ports
//   clk          single rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin a drain (only looked at while idle)
//   num_rows     rows to drain, clamped to ACC_DEPTH
//   shift        requant right-shift, clamped to P_BITWIDTH-1
//   relu_en      1: saturate to [0, 2^A-1], 0: signed saturation
//   busy         high from the cycle after start until done (inclusive)
//   done         one-cycle pulse closing the drain
//   acc_rd_en    accumulator read strobe
//   acc_rd_addr  accumulator row address
//   acc_rd_data  accumulator row, valid one cycle after acc_rd_en
//   out_valid    output beat valid
//   out_ready    downstream accept
//   out_data     requantized element
//   out_last     marks the final beat of the drain
// ---------------------------------------------------------------------------
module acc_drain #(
   parameter int SYS_COLS   = 8,
   parameter int P_BITWIDTH = 24,
   parameter int A_BITWIDTH = 8,
   parameter int ACC_DEPTH  = 16,
   parameter int ADDR_W     = $clog2(ACC_DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [ADDR_W:0]                num_rows,
   input  logic [4:0]                     shift,
   input  logic                           relu_en,
   output logic                           busy,
   output logic                           done,
   output logic                           acc_rd_en,
   output logic [ADDR_W-1:0]              acc_rd_addr,
   input  logic [SYS_COLS*P_BITWIDTH-1:0] acc_rd_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [A_BITWIDTH-1:0]          out_data,
   output logic                           out_last
);

   localparam int COL_W = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(SYS_COLS - 1);
   localparam logic [ADDR_W:0]   MAX_ROWS  = (ADDR_W + 1)'(ACC_DEPTH);
   localparam logic [4:0]        MAX_SHIFT = 5'(P_BITWIDTH - 1);

   // Saturation bounds, held at the widened requant width so that every
   // comparison below is a signed-to-signed comparison.
   localparam logic signed [P_BITWIDTH:0] SAT_ZERO = '0;
   localparam logic signed [P_BITWIDTH:0] SAT_UMAX = (P_BITWIDTH + 1)'((1 << A_BITWIDTH) - 1);
   localparam logic signed [P_BITWIDTH:0] SAT_SMAX = (P_BITWIDTH + 1)'((1 << (A_BITWIDTH - 1)) - 1);
   localparam logic signed [P_BITWIDTH:0] SAT_SMIN = (P_BITWIDTH + 1)'(-(1 << (A_BITWIDTH - 1)));

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      STREAM,
      DONE
   } state_t;

   state_t                        state;
   logic [ADDR_W:0]               count_q;
   logic [4:0]                    shift_q;
   logic                          relu_q;
   logic [ADDR_W-1:0]             row_cnt;
   logic [COL_W-1:0]              col_cnt;
   logic [SYS_COLS*P_BITWIDTH-1:0] row_reg;

   logic [ADDR_W:0]               num_rows_clamped;
   logic [4:0]                    shift_clamped;
   logic [ADDR_W:0]               row_inc;
   logic                          last_row;
   logic                          more_rows;

   logic [P_BITWIDTH-1:0]         elem;
   logic signed [P_BITWIDTH:0]    x_ext;
   logic signed [P_BITWIDTH:0]    rnd;
   logic signed [P_BITWIDTH:0]    sum;
   logic signed [P_BITWIDTH:0]    y;
   logic [A_BITWIDTH-1:0]         req_q;

   // Out-of-range requests are clamped here, before they are latched, so the
   // rest of the datapath only ever sees legal counts and shifts.
   assign num_rows_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
   assign shift_clamped    = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;

   // row_inc doubles as the "rows already finished after this one" count.
   // The row is the last one when that count reaches the latched total.
   assign row_inc   = {1'b0, row_cnt} + (ADDR_W + 1)'(1);
   assign last_row  = (row_inc == count_q);
   assign more_rows = (row_inc < count_q);

   // Requantization of the current element. It is fed only from the row
   // register, so acc_rd_data never reaches an output combinationally. The
   // rounding add runs one bit wider than the partial sum, so the add of
   // half an LSB cannot overflow even at the top of the input range.
   assign elem = row_reg[col_cnt * P_BITWIDTH +: P_BITWIDTH];

   always_comb begin
      x_ext = {elem[P_BITWIDTH-1], elem};
      rnd   = '0;
      sum   = x_ext;
      y     = x_ext;
      req_q = '0;
      if (shift_q != 5'd0) begin
         rnd = {{P_BITWIDTH{1'b0}}, 1'b1} << (shift_q - 5'd1);
         sum = x_ext + rnd;
         y   = sum >>> shift_q;
      end
      if (relu_q) begin
         if (y < SAT_ZERO) begin
            req_q = '0;
         end else if (y > SAT_UMAX) begin
            req_q = SAT_UMAX[A_BITWIDTH-1:0];
         end else begin
            req_q = y[A_BITWIDTH-1:0];
         end
      end else begin
         if (y < SAT_SMIN) begin
            req_q = SAT_SMIN[A_BITWIDTH-1:0];
         end else if (y > SAT_SMAX) begin
            req_q = SAT_SMAX[A_BITWIDTH-1:0];
         end else begin
            req_q = y[A_BITWIDTH-1:0];
         end
      end
   end

   // The data output is forced to zero whenever no beat is being offered.
   // This covers reset, and it keeps stale row contents off the bus while
   // the block is idle.
   assign out_data = out_valid ? req_q : '0;

   // Control FSM. All control outputs are registered, so each one is set on
   // the edge that enters the state in which it must be visible. A stalled
   // beat (out_valid high, out_ready low) leaves col_cnt and the row
   // register untouched, which keeps out_data and out_last stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count_q     <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         row_cnt     <= '0;
         col_cnt     <= '0;
         row_reg     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         acc_rd_en   <= 1'b0;
         acc_rd_addr <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
      end else begin
         done      <= 1'b0;
         acc_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  count_q <= num_rows_clamped;
                  shift_q <= shift_clamped;
                  relu_q  <= relu_en;
                  row_cnt <= '0;
                  col_cnt <= '0;
                  busy    <= 1'b1;
                  if (num_rows_clamped == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state       <= READ;
                     acc_rd_en   <= 1'b1;
                     acc_rd_addr <= '0;
                  end
               end
            end
            READ: begin
               state <= WAIT;
            end
            WAIT: begin
               row_reg   <= acc_rd_data;
               state     <= STREAM;
               out_valid <= 1'b1;
               out_last  <= last_row && (LAST_COL == '0);
            end
            STREAM: begin
               if (out_ready) begin
                  if (col_cnt == LAST_COL) begin
                     col_cnt   <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (more_rows) begin
                        row_cnt     <= row_inc[ADDR_W-1:0];
                        acc_rd_en   <= 1'b1;
                        acc_rd_addr <= row_inc[ADDR_W-1:0];
                        state       <= READ;
                     end else begin
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end else begin
                     col_cnt  <= col_cnt + COL_W'(1);
                     out_last <= last_row && ((col_cnt + COL_W'(1)) == LAST_COL);
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_drain.sv
// ---------------------------------------------------------------------------
// tb_acc_drain
//
// Testbench for acc_drain. The bench holds an accumulator memory model that
// answers read strobes one cycle later.
//
// Whenever a drain is launched, the full expected beat stream is pushed into
// a queue. The reference requantizer produces that stream with plain integer
// arithmetic: floor division with rounding, followed by clamping.
//
// An independent negedge monitor compares every offered beat against the head
// of that queue, and pops the head only when the beat is accepted. It also
// logs every read address.
// ---------------------------------------------------------------------------
module tb_acc_drain;

   localparam int SYS_COLS   = 8;
   localparam int P_BITWIDTH = 24;
   localparam int A_BITWIDTH = 8;
   localparam int ACC_DEPTH  = 16;
   localparam int ADDR_W     = $clog2(ACC_DEPTH);
   localparam int ROW_W      = SYS_COLS * P_BITWIDTH;
   localparam int WAIT_LIMIT = 3000;

   typedef struct {
      int data;
      int last;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic [ADDR_W:0]       num_rows = '0;
   logic [4:0]            shift = '0;
   logic                  relu_en = 1'b0;
   logic                  busy;
   logic                  done;
   logic                  acc_rd_en;
   logic [ADDR_W-1:0]     acc_rd_addr;
   logic [ROW_W-1:0]      acc_rd_data = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [A_BITWIDTH-1:0] out_data;
   logic                  out_last;

   logic [ROW_W-1:0] acc_mem [ACC_DEPTH];
   beat_t            exp_q[$];
   int               rd_log[$];
   int               checks = 0;
   int               passes = 0;
   int               cyc = 0;
   int               beat_cnt = 0;
   int               first_beat_cyc = -1;
   int               start_cyc = 0;
   bit               rand_ready = 1'b0;

   acc_drain #(
      .SYS_COLS  (SYS_COLS),
      .P_BITWIDTH(P_BITWIDTH),
      .A_BITWIDTH(A_BITWIDTH),
      .ACC_DEPTH (ACC_DEPTH),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_rows   (num_rows),
      .shift      (shift),
      .relu_en    (relu_en),
      .busy       (busy),
      .done       (done),
      .acc_rd_en  (acc_rd_en),
      .acc_rd_addr(acc_rd_addr),
      .acc_rd_data(acc_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
   );

   // Free-running clock, plus a cycle index that advances on every rising
   // edge. Latencies are measured in units of that index.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Accumulator buffer model: returns the addressed row one cycle after the
   // read strobe.
   always @(posedge clk) begin
      if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
   end

   // Downstream consumer: either always ready, or ready on a coin flip.
   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? 1'($urandom) : 1'b1;
   end

   // Watchdog, so that the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point. Every check passes through here.
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual == expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference requantizer: round half up via floor((x + d/2) / d), then
   // clamp to the selected output range. The result is returned as the
   // output byte pattern.
   function automatic int ref_requant(input longint x, input int s, input bit relu);
      longint d;
      longint num;
      longint y;
      logic [63:0] bits;
      if (s == 0) begin
         y = x;
      end else begin
         d   = longint'(1) << s;
         num = x + d / 2;
         y   = num / d;
         if ((num % d != 0) && (num < 0)) y = y - 1;
      end
      if (relu) y = (y < 0) ? 0 : ((y > 255) ? 255 : y);
      else      y = (y < -128) ? -128 : ((y > 127) ? 127 : y);
      bits = y;
      return int'(bits[A_BITWIDTH-1:0]);
   endfunction

   function automatic longint get_elem(input int r, input int c);
      logic [P_BITWIDTH-1:0] e;
      e = acc_mem[r][c*P_BITWIDTH +: P_BITWIDTH];
      return longint'($signed(e));
   endfunction

   task automatic set_elem(input int r, input int c, input int v);
      logic [31:0] vv;
      vv = v;
      acc_mem[r][c*P_BITWIDTH +: P_BITWIDTH] = vv[P_BITWIDTH-1:0];
   endtask

   task automatic fill_random();
      int v;
      for (int r = 0; r < ACC_DEPTH; r++) begin
         for (int c = 0; c < SYS_COLS; c++) begin
            v = int'($urandom_range(0, 2000)) - 1000;
            if (($urandom & 3) == 0) v = int'($urandom) >>> 8;
            set_elem(r, c, v);
         end
      end
   endtask

   // Pushes the whole expected beat stream for one drain.
   task automatic push_expected(input int rows, input int sh, input bit relu, output int cnt);
      int    s;
      beat_t b;
      cnt = (rows > ACC_DEPTH) ? ACC_DEPTH : rows;
      s   = (sh > P_BITWIDTH - 1) ? P_BITWIDTH - 1 : sh;
      for (int r = 0; r < cnt; r++) begin
         for (int c = 0; c < SYS_COLS; c++) begin
            b.data = ref_requant(get_elem(r, c), s, relu);
            b.last = ((r == cnt - 1) && (c == SYS_COLS - 1)) ? 1 : 0;
            exp_q.push_back(b);
         end
      end
   endtask

   // Called at posedge+1. Drives start for one cycle and returns in cycle 1.
   task automatic applyStimulus(input int rows, input int sh, input bit relu, output int cnt);
      logic [31:0] rv;
      logic [31:0] sv;
      push_expected(rows, sh, relu, cnt);
      rd_log.delete();
      beat_cnt       = 0;
      first_beat_cyc = -1;
      rv             = rows;
      sv             = sh;
      start          = 1'b1;
      num_rows       = rv[ADDR_W:0];
      shift          = sv[4:0];
      relu_en        = relu;
      start_cyc      = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Runs one complete drain and returns in the first idle cycle after done.
   // inject: randomly pulse start while busy, and always in the done cycle.
   task automatic run_drain(input int rows, input int sh, input bit relu,
                            input bit rnd_ready, input bit inject, input bit timed);
      int cnt;
      int done_at;
      bit got;
      rand_ready = rnd_ready;
      applyStimulus(rows, sh, relu, cnt);
      checkOutput("c1_busy", busy, 1);
      checkOutput("c1_rd_en", acc_rd_en, (cnt != 0) ? 1 : 0);
      checkOutput("c1_done", done, (cnt == 0) ? 1 : 0);
      if (cnt != 0) checkOutput("c1_rd_addr", acc_rd_addr, 0);
      got     = 1'b0;
      done_at = -1;
      for (int i = 0; i < WAIT_LIMIT && !got; i++) begin
         if (done) begin
            got     = 1'b1;
            done_at = cyc;
            start   = inject;
         end else begin
            if (inject) start = 1'($urandom);
            num_rows = (ADDR_W + 1)'($urandom);
            shift    = 5'($urandom);
            relu_en  = 1'($urandom);
            @(posedge clk);
            #1;
         end
      end
      checkOutput("done_seen", got, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_rd_en", acc_rd_en, 0);
      checkOutput("beats_left", exp_q.size(), 0);
      checkOutput("beat_count", beat_cnt, cnt * SYS_COLS);
      checkOutput("read_count", rd_log.size(), cnt);
      for (int i = 0; i < rd_log.size() && i < cnt; i++) checkOutput("read_addr", rd_log[i], i);
      if (timed) begin
         checkOutput("done_cycle", done_at - start_cyc, 1 + cnt * (SYS_COLS + 2));
         if (cnt != 0) checkOutput("first_beat_cycle", first_beat_cyc - start_cyc, 3);
      end
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_rd_en"}, acc_rd_en, 0);
      checkOutput({tag, "_rd_addr"}, acc_rd_addr, 0);
      checkOutput({tag, "_valid"}, out_valid, 0);
      checkOutput({tag, "_last"}, out_last, 0);
      checkOutput({tag, "_data"}, out_data, 0);
   endtask

   // Scoreboard monitor. It samples on the falling edge, checks every
   // offered beat against the head of the expected queue, and pops the head
   // only on an accepted beat. During a stall the same head is checked again
   // on the next cycle, which also verifies that the beat holds steady.
   always @(negedge clk) begin
      if (rst_n) begin
         if (acc_rd_en) rd_log.push_back(int'(acc_rd_addr));
         if (out_valid) begin
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_beat", out_valid, 0);
            end else begin
               checkOutput("beat_data", out_data, exp_q[0].data);
               checkOutput("beat_last", out_last, exp_q[0].last);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  beat_cnt++;
               end
            end
         end else begin
            checkOutput("last_without_valid", out_last, 0);
         end
      end
   end

   initial begin
      int rv[SYS_COLS];
      int cnt;
      bit got;

      rv = '{300, -300, 383, 384, -129, 127, 0, -1};
      for (int r = 0; r < ACC_DEPTH; r++) acc_mem[r] = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single row, no shift");
      for (int c = 0; c < SYS_COLS; c++) set_elem(0, c, c);
      run_drain(1, 0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] rounding and saturation");
      for (int c = 0; c < SYS_COLS; c++) set_elem(0, c, rv[c]);
      run_drain(1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
      run_drain(1, 0, 1'b1, 1'b0, 1'b0, 1'b1);

      $display("[TB] full drain under backpressure");
      for (int r = 0; r < ACC_DEPTH; r++)
         for (int c = 0; c < SYS_COLS; c++) set_elem(r, c, r * SYS_COLS + c);
      run_drain(16, 0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] edge counts");
      run_drain(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      fill_random();
      run_drain(20, 3, 1'b0, 1'b0, 1'b0, 1'b1);
      set_elem(0, 0, 'h7FFFFF);
      run_drain(1, 31, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] start during operation");
      fill_random();
      run_drain(3, 2, 1'b1, 1'b1, 1'b1, 1'b0);
      run_drain(2, 4, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] random drains");
      for (int k = 0; k < 4; k++) begin
         fill_random();
         run_drain(int'($urandom_range(1, ACC_DEPTH)), int'($urandom_range(0, 31)),
                   1'($urandom), 1'b1, 1'b0, 1'b0);
      end

      $display("[TB] reset mid-stream");
      fill_random();
      rand_ready = 1'b0;
      applyStimulus(16, 2, 1'b0, cnt);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         if (out_valid && (beat_cnt == SYS_COLS + 3)) begin
            got = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      checkOutput("reached_row1_beat3", got, 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_drain(2, 0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
